// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner selection for a shared tristate bus. Each grant drives one SIZE-bit oe slice,
// and every change of owner (or re-grant) is separated by TURN+1 cycles with all oe low.
module tristate_bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int SIZE    = 8,
  parameter int TURN    = 1,
  parameter int MAXHOLD = 16,
  parameter int IDXW    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ*SIZE-1:0] oe,
  output logic [IDXW-1:0]      owner,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  // Handshake: req is a level held by a driver for as long as it wants the bus.
  // gnt rises one edge after req is sampled in IDLE and falls one edge after release.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } state_t;

  localparam int HW = (MAXHOLD < 2) ? 1 : $clog2(MAXHOLD);
  localparam int TW = (TURN < 2) ? 1 : $clog2(TURN);
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAXHOLD == 0) ? 0 : MAXHOLD - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'((TURN == 0) ? 0 : TURN - 1);
  localparam bit HOLD_EN = (MAXHOLD != 0);
  localparam bit TURN_EN = (TURN != 0);

  state_t          state, state_d;
  logic [NREQ-1:0] gnt_d;
  logic [IDXW-1:0] owner_d, rr_ptr, rr_d;
  logic [HW-1:0]   hold_cnt, hold_d;
  logic [TW-1:0]   tcnt, tcnt_d;

  logic            found;
  logic [IDXW-1:0] sel, cand;
  logic            others, release_c;

  // Rotating scan starting at rr_ptr; the first requester found wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDXW'((int'(rr_ptr) + i) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // A competitor only forces release once the owner has used its full hold window.
  always_comb begin
    others    = |(req & ~gnt);
    release_c = !req[owner] || (HOLD_EN && (hold_cnt == HOLD_LAST) && others);
  end

  always_comb begin
    state_d = state;
    gnt_d   = gnt;
    owner_d = owner;
    rr_d    = rr_ptr;
    hold_d  = hold_cnt;
    tcnt_d  = tcnt;
    case (state)
      ST_IDLE: begin
        if (found) begin
          gnt_d   = NREQ'(1) << sel;
          owner_d = sel;
          rr_d    = (sel == IDXW'(NREQ - 1)) ? '0 : sel + 1'b1;
          hold_d  = '0;
          state_d = ST_OWN;
        end
      end
      ST_OWN: begin
        hold_d = (&hold_cnt) ? hold_cnt : hold_cnt + 1'b1;
        if (release_c) begin
          gnt_d = '0;
          if (TURN_EN) begin
            state_d = ST_TURN;
            tcnt_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_TURN: begin
        tcnt_d = tcnt + 1'b1;
        if (tcnt == TURN_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      tcnt     <= '0;
    end else begin
      state    <= state_d;
      gnt      <= gnt_d;
      owner    <= owner_d;
      rr_ptr   <= rr_d;
      hold_cnt <= hold_d;
      tcnt     <= tcnt_d;
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_oe
    assign oe[g*SIZE +: SIZE] = {SIZE{gnt[g]}};
  end

  assign busy      = |gnt;
  assign dbg_state = state;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed checks of the tristate bus arbiter: a TURN=1/MAXHOLD=16 instance for grant,
// rotation, hold and reset behaviour, and a TURN=0/MAXHOLD=4 instance for back-to-back turnaround.
module tb_tristate_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  req0 = '0;

  logic [3:0]  gnt, gnt0;
  logic [31:0] oe, oe0;
  logic [1:0]  owner, owner0;
  logic        busy, busy0;
  logic [1:0]  dbg_state, dbg_state0;

  int vectors = 0;
  int miscompares = 0;
  int len, dead;

  always #5 clk = ~clk;

  tristate_bus_arbiter #(.NREQ(4), .SIZE(8), .TURN(1), .MAXHOLD(16), .IDXW(2)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .oe(oe),
    .owner(owner), .busy(busy), .dbg_state(dbg_state)
  );

  tristate_bus_arbiter #(.NREQ(4), .SIZE(8), .TURN(0), .MAXHOLD(4), .IDXW(2)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .gnt(gnt0), .oe(oe0),
    .owner(owner0), .busy(busy0), .dbg_state(dbg_state0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rep(input logic [3:0] g);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = {8{g[i]}};
    return r;
  endfunction

  task automatic inv_check();
    check("onehot", 32'($countones(gnt) <= 1), 32'd1);
    check("oe_rep", oe, rep(gnt));
    check("busy_or", 32'(busy), 32'(|gnt));
    check("onehot0", 32'($countones(gnt0) <= 1), 32'd1);
    check("oe_rep0", oe0, rep(gnt0));
    check("busy_or0", 32'(busy0), 32'(|gnt0));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      inv_check();
    end
  endtask

  initial begin
    // Reset
    step(2);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_oe", oe, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    rst = 1'b0;

    // Single requester: one-cycle latency, release and 2 dead cycles
    req = 4'b0001;
    step(1);
    check("t1_gnt", 32'(gnt), 32'h1);
    check("t1_oe", oe, 32'h0000_00FF);
    check("t1_owner", 32'(owner), 32'h0);
    check("t1_busy", 32'(busy), 32'h1);
    req = 4'b0000;
    step(1);
    check("t1_drop", 32'(gnt), 32'h0);
    req = 4'b0001;
    step(1);
    check("t1_dead2", 32'(gnt), 32'h0);
    check("t1_idle_owner", 32'(owner), 32'h0);
    step(1);
    check("t1_regrant", 32'(gnt), 32'h1);
    req = 4'b0000;
    step(2);

    // Lone requester keeps the bus past MAXHOLD
    req = 4'b0100;
    step(1);
    check("t3_gnt", 32'(gnt), 32'h4);
    check("t3_owner", 32'(owner), 32'h2);
    len = 0;
    for (int c = 0; c < 40; c++) begin
      if (gnt === 4'b0100) len++;
      step(1);
    end
    check("t3_held", 32'(len), 32'd40);
    req = 4'b0000;
    step(2);

    // All request after reset: rotation 0,1,2,3,0, 16-cycle grants, 2 dead cycles
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    req = 4'b1111;
    step(1);
    for (int k = 0; k < 5; k++) begin
      check("t2_rot", 32'(gnt), 32'(4'b0001 << (k % 4)));
      len = 0;
      while (gnt === (4'b0001 << (k % 4)) && len < 100) begin
        len++;
        step(1);
      end
      check("t2_len", 32'(len), 32'd16);
      if (k < 4) begin
        dead = 0;
        while (oe === 32'h0 && dead < 100) begin
          dead++;
          step(1);
        end
        check("t2_dead", 32'(dead), 32'd2);
      end
    end
    req = 4'b0000;
    step(2);

    // Owner 1 keeps the bus until hold_cnt 15 after req[3] rises at hold_cnt 5
    req = 4'b0010;
    step(1);
    check("t4_gnt", 32'(gnt), 32'h2);
    step(5);
    req = 4'b1010;
    len = 0;
    while (gnt === 4'b0010 && len < 100) begin
      len++;
      step(1);
    end
    check("t4_rest", 32'(len), 32'd11);
    dead = 0;
    while (oe === 32'h0 && dead < 100) begin
      dead++;
      step(1);
    end
    check("t4_dead", 32'(dead), 32'd2);
    check("t4_next", 32'(gnt), 32'h8);
    check("t4_owner", 32'(owner), 32'h3);

    // Reset mid-grant, then first grant goes to 0
    req = 4'b0010;
    step(3);
    check("t5_pre", 32'(gnt), 32'h2);
    rst = 1'b1;
    req = 4'b1111;
    step(1);
    check("t5_gnt", 32'(gnt), 32'h0);
    check("t5_oe", oe, 32'h0);
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_owner", 32'(owner), 32'h0);
    rst = 1'b0;
    step(1);
    check("t5_first", 32'(gnt), 32'h1);
    check("t5_first_owner", 32'(owner), 32'h0);
    req = 4'b0000;
    step(2);

    // TURN=0 instance: exactly one dead cycle between owners
    req0 = 4'b0011;
    step(1);
    check("t6_gnt_a", 32'(gnt0), 32'h1);
    for (int k = 0; k < 2; k++) begin
      len = 0;
      while (gnt0 === (4'b0001 << k) && len < 100) begin
        len++;
        step(1);
      end
      check("t6_len", 32'(len), 32'd4);
      dead = 0;
      while (oe0 === 32'h0 && dead < 100) begin
        dead++;
        step(1);
      end
      check("t6_dead", 32'(dead), 32'd1);
      check("t6_next", 32'(gnt0), 32'(4'b0001 << (1 - k)));
    end

    // Random request traffic on both instances under the per-cycle invariants
    for (int c = 0; c < 300; c++) begin
      req  = 4'($urandom_range(0, 15));
      req0 = 4'($urandom_range(0, 15));
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
